reg_register_int_ctrl: RTL and testbench

Parametrised interrupt controller register block: successor to the single-bit interrupt mask register. It captures INT_NUM interrupt sources into sticky status bits, with per-channel edge or level detection and an optional input synchronizer. It exposes STATUS (W1C), MASK (RW), RAW (RO) and OVERFLOW (W1C) registers on the standard sel/rd-wr register port. It drives one registered, masked interrupt line to the CPU-side interrupt aggregator.

---
 rtl/reg_int_pkg.sv | 15 +
 rtl/reg_register_int_ctrl_if.sv | 36 +++
 rtl/reg_int_sync.sv | 57 +++++
 rtl/reg_register_int_ctrl.sv | 127 ++++++++++++
 tb/tb_reg_register_int_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_int_pkg.sv
// -----------------------------------------------------------------------------
// reg_int_pkg
// Shared definitions for the interrupt controller register block: the 2-bit
// register address type and the address map of the four registers.
// -----------------------------------------------------------------------------
package reg_int_pkg;

    typedef logic [1:0] int_addr_t;

    localparam int_addr_t INT_ADDR_STATUS = 2'd0;  // sticky status, write-1-to-clear
    localparam int_addr_t INT_ADDR_MASK   = 2'd1;  // 1 = channel masked from int_out
    localparam int_addr_t INT_ADDR_RAW    = 2'd2;  // synchronized source levels, read-only
    localparam int_addr_t INT_ADDR_OVF    = 2'd3;  // lost-edge flags, write-1-to-clear

endpackage : reg_int_pkg

// File: rtl/reg_register_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_register_int_ctrl_if
// Register access port of the interrupt controller.
//   reg_wr_sel  : access strobe (one cycle per access, back-to-back allowed)
//   reg_wr_rd   : 1 = write, 0 = read
//   reg_addr    : register select (see reg_int_pkg)
//   reg_wr_data : write data
//   reg_rd_out  : registered read data, valid while reg_rd is high
//   reg_rd      : read-done pulse, one cycle after the read
//   reg_wr      : write-done pulse, one cycle after the write
// Modports: master (CPU side), slave (register block).
// -----------------------------------------------------------------------------
interface reg_register_int_ctrl_if #(
    parameter int REG_WIDTH = 32
);
    import reg_int_pkg::*;

    logic                 reg_wr_sel;
    logic                 reg_wr_rd;
    int_addr_t            reg_addr;
    logic [REG_WIDTH-1:0] reg_wr_data;
    logic [REG_WIDTH-1:0] reg_rd_out;
    logic                 reg_rd;
    logic                 reg_wr;

    modport master (
        output reg_wr_sel, reg_wr_rd, reg_addr, reg_wr_data,
        input  reg_rd_out, reg_rd, reg_wr
    );

    modport slave (
        input  reg_wr_sel, reg_wr_rd, reg_addr, reg_wr_data,
        output reg_rd_out, reg_rd, reg_wr
    );

endinterface : reg_register_int_ctrl_if

// File: rtl/reg_int_sync.sv
// -----------------------------------------------------------------------------
// reg_int_sync
// Per-channel input conditioning for the interrupt sources: an optional
// 2-flop synchronizer followed by a one-cycle delay used for edge detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   src_in     : raw interrupt sources
//   src_s      : synchronized (or bypassed) sources
//   src_rise   : rising-edge vector, src_s & ~src_s delayed by one clock
// -----------------------------------------------------------------------------
module reg_int_sync #(
    parameter int INT_NUM = 8,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] src_in,
    output logic [INT_NUM-1:0] src_s,
    output logic [INT_NUM-1:0] src_rise
);

    logic [INT_NUM-1:0] src_d;

    generate
        if (SYNC_EN) begin : g_sync
            logic [INT_NUM-1:0] meta;
            logic [INT_NUM-1:0] stable;

            // NOTE: state flops use non-blocking assignments so that every flop
            // samples the pre-edge value; a blocking meta->stable chain would
            // collapse the two stages into one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta   <= '0;
                    stable <= '0;
                end else begin
                    meta   <= src_in;
                    stable <= meta;
                end
            end

            assign src_s = stable;
        end else begin : g_bypass
            assign src_s = src_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d <= '0;
        end else begin
            src_d <= src_s;
        end
    end

    assign src_rise = src_s & ~src_d;

endmodule : reg_int_sync

// File: rtl/reg_register_int_ctrl.sv
// -----------------------------------------------------------------------------
// reg_register_int_ctrl
// Interrupt controller register block. Captures INT_NUM sources into sticky
// STATUS bits (edge or level per channel), records lost edges in OVERFLOW,
// and drives one registered, masked interrupt request.
//   clk, rst_n   : clock, asynchronous active-low reset
//   int_src      : raw interrupt sources
//   bus          : register port (slave modport), registers:
//                  0 STATUS (W1C), 1 MASK (RW), 2 RAW (RO), 3 OVERFLOW (W1C)
//   int_out      : |(STATUS & ~MASK), registered
//   int_stat_out : live STATUS bits
// -----------------------------------------------------------------------------
module reg_register_int_ctrl
    import reg_int_pkg::*;
#(
    parameter int                 REG_WIDTH    = 32,
    parameter int                 INT_NUM      = 8,
    parameter logic [INT_NUM-1:0] INT_EDGE     = {INT_NUM{1'b1}},
    parameter logic [INT_NUM-1:0] MASK_DEFAULT = {INT_NUM{1'b1}},
    parameter bit                 SYNC_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INT_NUM-1:0]      int_src,
    reg_register_int_ctrl_if.slave  bus,
    output logic                    int_out,
    output logic [INT_NUM-1:0]      int_stat_out
);

    logic [INT_NUM-1:0]   src_s;
    logic [INT_NUM-1:0]   src_rise;
    logic [INT_NUM-1:0]   evt;

    logic [INT_NUM-1:0]   status_q, status_nxt;
    logic [INT_NUM-1:0]   mask_q, mask_nxt;
    logic [INT_NUM-1:0]   ovf_q, ovf_nxt;

    logic                 wr_stb;
    logic                 rd_stb;
    logic [INT_NUM-1:0]   wr_bits;
    logic [INT_NUM-1:0]   stat_clr;
    logic [INT_NUM-1:0]   ovf_clr;
    logic [REG_WIDTH-1:0] rd_data;

    reg_int_sync #(
        .INT_NUM (INT_NUM),
        .SYNC_EN (SYNC_EN)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_in   (int_src),
        .src_s    (src_s),
        .src_rise (src_rise)
    );

    // Edge channels fire once per rising edge; level channels fire every
    // cycle the source is high, which is why a W1C cannot stick on them.
    assign evt = (INT_EDGE & src_rise) | (~INT_EDGE & src_s);

    assign wr_stb  = bus.reg_wr_sel &  bus.reg_wr_rd;
    assign rd_stb  = bus.reg_wr_sel & ~bus.reg_wr_rd;
    assign wr_bits = bus.reg_wr_data[INT_NUM-1:0];

    // Data bits above the channel count have no storage behind them.
    generate
        if (INT_NUM < REG_WIDTH) begin : g_unused_hi
            logic unused_wr_hi;
            assign unused_wr_hi = ^bus.reg_wr_data[REG_WIDTH-1:INT_NUM];
        end
    endgenerate

    assign stat_clr = (wr_stb && bus.reg_addr == INT_ADDR_STATUS) ? wr_bits : '0;
    assign ovf_clr  = (wr_stb && bus.reg_addr == INT_ADDR_OVF)    ? wr_bits : '0;

    // NOTE: every variable written here gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        status_nxt = (status_q & ~stat_clr) | evt;
        // An edge landing on an already-pending bit is a lost interrupt,
        // unless software is acknowledging that bit in the same cycle.
        ovf_nxt    = ((ovf_q & ~ovf_clr) | (evt & status_q & ~stat_clr)) & INT_EDGE;
        mask_nxt   = mask_q;
        rd_data    = '0;

        if (wr_stb && bus.reg_addr == INT_ADDR_MASK) begin
            mask_nxt = wr_bits;
        end

        // Reads return pre-edge register contents, zero-extended.
        if (rd_stb) begin
            case (bus.reg_addr)
                INT_ADDR_STATUS: rd_data[INT_NUM-1:0] = status_q;
                INT_ADDR_MASK:   rd_data[INT_NUM-1:0] = mask_q;
                INT_ADDR_RAW:    rd_data[INT_NUM-1:0] = src_s;
                INT_ADDR_OVF:    rd_data[INT_NUM-1:0] = ovf_q;
                default:         rd_data              = '0;
            endcase
        end
    end

    // NOTE: all state here is a handful of control flops, so every one of
    // them sits on the asynchronous reset; a reset mid-access clears the
    // pending pulse before it can be issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q       <= '0;
            mask_q         <= MASK_DEFAULT;
            ovf_q          <= '0;
            int_out        <= 1'b0;
            bus.reg_rd_out <= '0;
            bus.reg_rd     <= 1'b0;
            bus.reg_wr     <= 1'b0;
        end else begin
            status_q       <= status_nxt;
            mask_q         <= mask_nxt;
            ovf_q          <= ovf_nxt;
            // Uses current register values: a change at edge k shows at k+1.
            int_out        <= |(status_q & ~mask_q);
            bus.reg_rd_out <= rd_data;
            bus.reg_rd     <= rd_stb;
            bus.reg_wr     <= wr_stb;
        end
    end

    assign int_stat_out = status_q;

endmodule : reg_register_int_ctrl

// File: tb/tb_reg_register_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_register_int_ctrl
// Self-checking bench: directed scenarios followed by random traffic. A
// cycle-level reference model predicts every output; read data is queued when
// a read is issued and popped by a monitor when the DUT raises reg_rd.
// -----------------------------------------------------------------------------
module tb_reg_register_int_ctrl;
    import reg_int_pkg::*;

    localparam int         REG_WIDTH    = 32;
    localparam int         INT_NUM      = 8;
    localparam logic [7:0] INT_EDGE     = 8'hDF;  // channel 5 is level
    localparam logic [7:0] MASK_DEFAULT = 8'hFF;
    localparam bit         SYNC_EN      = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] int_src = '0;
    logic       int_out;
    logic [7:0] int_stat_out;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    reg_register_int_ctrl_if #(.REG_WIDTH(REG_WIDTH)) bus ();

    reg_register_int_ctrl #(
        .REG_WIDTH    (REG_WIDTH),
        .INT_NUM      (INT_NUM),
        .INT_EDGE     (INT_EDGE),
        .MASK_DEFAULT (MASK_DEFAULT),
        .SYNC_EN      (SYNC_EN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_src      (int_src),
        .bus          (bus),
        .int_out      (int_out),
        .int_stat_out (int_stat_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_status, m_mask, m_ovf;
    logic        m_int, m_rd, m_wr;
    logic [7:0]  hist [3];   // int_src samples, [0] = most recent edge
    logic [31:0] exp_q [$];

    task automatic model_reset();
        m_status = '0;
        m_mask   = MASK_DEFAULT;
        m_ovf    = '0;
        m_int    = 1'b0;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] s_now, s_prev, rv;
        logic       rd, wr, ev, sclr, oclr;
        // Synchronized view is the source two edges old; previous one older.
        s_now  = SYNC_EN ? hist[1] : int_src;
        s_prev = SYNC_EN ? hist[2] : hist[0];
        rd = bus.reg_wr_sel && !bus.reg_wr_rd;
        wr = bus.reg_wr_sel &&  bus.reg_wr_rd;
        if (rd) begin
            case (bus.reg_addr)
                INT_ADDR_STATUS: rv = m_status;
                INT_ADDR_MASK:   rv = m_mask;
                INT_ADDR_RAW:    rv = s_now;
                default:         rv = m_ovf;
            endcase
            exp_q.push_back({24'h0, rv});
        end
        m_rd  = rd;
        m_wr  = wr;
        m_int = |(m_status & ~m_mask);
        for (int i = 0; i < 8; i++) begin
            ev   = INT_EDGE[i] ? (s_now[i] && !s_prev[i]) : s_now[i];
            sclr = wr && bus.reg_addr == INT_ADDR_STATUS && bus.reg_wr_data[i];
            oclr = wr && bus.reg_addr == INT_ADDR_OVF    && bus.reg_wr_data[i];
            if (!INT_EDGE[i])                   m_ovf[i] = 1'b0;
            else if (ev && m_status[i] && !sclr) m_ovf[i] = 1'b1;
            else if (oclr)                      m_ovf[i] = 1'b0;
            if (ev)        m_status[i] = 1'b1;
            else if (sclr) m_status[i] = 1'b0;
        end
        if (wr && bus.reg_addr == INT_ADDR_MASK) m_mask = bus.reg_wr_data[7:0];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int_src;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                check("mon_int_out", {31'b0, int_out}, {31'b0, m_int});
                check("mon_status", {24'b0, int_stat_out}, {24'b0, m_status});
                check("mon_rd_pulse", {31'b0, bus.reg_rd}, {31'b0, m_rd});
                check("mon_wr_pulse", {31'b0, bus.reg_wr}, {31'b0, m_wr});
                if (bus.reg_rd && exp_q.size() > 0)
                    check("mon_rd_data", bus.reg_rd_out, exp_q.pop_front());
                else if (!bus.reg_rd)
                    check("mon_rd_idle", bus.reg_rd_out, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input int_addr_t a, input logic [31:0] d);
        bus.reg_wr_sel  = 1'b1;
        bus.reg_wr_rd   = 1'b1;
        bus.reg_addr    = a;
        bus.reg_wr_data = d;
        @(negedge clk);
        bus.reg_wr_sel  = 1'b0;
    endtask

    task automatic read_expect(input string name, input int_addr_t a, input logic [31:0] exp);
        bus.reg_wr_sel  = 1'b1;
        bus.reg_wr_rd   = 1'b0;
        bus.reg_addr    = a;
        bus.reg_wr_data = $urandom;
        @(negedge clk);
        bus.reg_wr_sel  = 1'b0;
        check(name, bus.reg_rd_out, exp);
    endtask

    task automatic pulse(input int ch);
        int_src[ch] = 1'b1;
        @(negedge clk);
        int_src[ch] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  lat;
        bit  seen;
        bus.reg_wr_sel  = 1'b0;
        bus.reg_wr_rd   = 1'b0;
        bus.reg_addr    = '0;
        bus.reg_wr_data = '0;

        // Reset with activity on the inputs: outputs must stay quiet.
        repeat (3) begin
            @(negedge clk);
            int_src        = 8'($urandom);
            bus.reg_wr_sel = 1'b1;
        end
        check("rst_int_out", {31'b0, int_out}, 32'h0);
        check("rst_rd_out", bus.reg_rd_out, 32'h0);
        check("rst_pulses", {30'b0, bus.reg_rd, bus.reg_wr}, 32'h0);
        check("rst_status", {24'b0, int_stat_out}, 32'h0);
        bus.reg_wr_sel = 1'b0;
        int_src        = '0;
        idle(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(4);

        read_expect("reset_mask", INT_ADDR_MASK, 32'hFF);
        read_expect("reset_status", INT_ADDR_STATUS, 32'h0);

        // Unmasked channel 0: latency through the synchronizer, then W1C.
        do_write(INT_ADDR_MASK, 32'hFFFF_FFFE);
        int_src[0] = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) int_src[0] = 1'b0;
            if (int_out) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("int_latency", lat, 4);
        read_expect("ch0_status", INT_ADDR_STATUS, 32'h01);
        do_write(INT_ADDR_STATUS, 32'h01);
        check("w1c_int_still_high", {31'b0, int_out}, 32'h1);
        @(negedge clk);
        check("w1c_int_low", {31'b0, int_out}, 32'h0);

        // Edge channel 3: two edges without acknowledge set OVERFLOW.
        pulse(3);
        idle(5);
        pulse(3);
        idle(5);
        read_expect("ch3_status", INT_ADDR_STATUS, 32'h08);
        read_expect("ch3_ovf", INT_ADDR_OVF, 32'h08);
        do_write(INT_ADDR_OVF, 32'h08);
        read_expect("ch3_ovf_clr", INT_ADDR_OVF, 32'h00);
        do_write(INT_ADDR_STATUS, 32'h08);

        // Channel 2: edge arrives in the same cycle as its W1C.
        pulse(2);
        idle(5);
        int_src[2] = 1'b1;
        idle(2);
        do_write(INT_ADDR_STATUS, 32'h04);
        int_src[2] = 1'b0;
        read_expect("same_cycle_status", INT_ADDR_STATUS, 32'h04);
        read_expect("same_cycle_ovf", INT_ADDR_OVF, 32'h00);
        do_write(INT_ADDR_STATUS, 32'h04);
        idle(3);

        // Level channel 5: W1C does not stick while the source is high.
        int_src[5] = 1'b1;
        idle(4);
        do_write(INT_ADDR_STATUS, 32'h20);
        read_expect("level_status_held", INT_ADDR_STATUS, 32'h20);
        read_expect("level_raw_high", INT_ADDR_RAW, 32'h20);
        int_src[5] = 1'b0;
        idle(4);
        do_write(INT_ADDR_STATUS, 32'h20);
        read_expect("level_status_clr", INT_ADDR_STATUS, 32'h00);
        read_expect("level_raw_low", INT_ADDR_RAW, 32'h00);
        read_expect("level_ovf_zero", INT_ADDR_OVF, 32'h00);

        // Masked channel 1 latches but does not interrupt until unmasked.
        do_write(INT_ADDR_MASK, 32'hFF);
        pulse(1);
        idle(5);
        read_expect("masked_status", INT_ADDR_STATUS, 32'h02);
        check("masked_int_low", {31'b0, int_out}, 32'h0);
        do_write(INT_ADDR_MASK, 32'hFD);
        check("unmask_wr_pulse", {31'b0, bus.reg_wr}, 32'h1);
        check("unmask_int_not_yet", {31'b0, int_out}, 32'h0);
        @(negedge clk);
        check("unmask_wr_pulse_end", {31'b0, bus.reg_wr}, 32'h0);
        check("unmask_int_high", {31'b0, int_out}, 32'h1);
        read_expect("mask_readback", INT_ADDR_MASK, 32'hFD);
        do_write(INT_ADDR_STATUS, 32'hFF);

        // Random traffic, back-to-back accesses included; model checks all.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0)
                int_src[$urandom_range(0, 7)] = 1'($urandom);
            bus.reg_wr_sel  = 1'($urandom_range(0, 9) < 6);
            bus.reg_wr_rd   = 1'($urandom);
            bus.reg_addr    = int_addr_t'($urandom);
            bus.reg_wr_data = $urandom;
            @(negedge clk);
        end
        bus.reg_wr_sel = 1'b0;
        idle(6);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_register_int_ctrl
